note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, note RAM address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter NOTE_W, default 8, width of one note word.
REQ-003 SHALL have parameter TICK_DIV, default 25000000, clock cycles per played note (≥2).
REQ-004 SHALL have port clock  input  1  the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_p  input  1  debounced one-cycle pulse: new session / abort.
REQ-007 SHALL have port record_p  input  1  debounced one-cycle pulse: store current sw_tones.
REQ-008 SHALL have port execute_p  input  1  debounced one-cycle pulse: begin playback.
REQ-009 SHALL have port sw_tones  input  NOTE_W  live switch note word, forwarded to RAM write data.
REQ-010 SHALL have port ram_we  output  1  RAM write enable, one-cycle pulse.
REQ-011 SHALL have port ram_waddr  output  ADDR_W  RAM write address.
REQ-012 SHALL have port ram_wdata  output  NOTE_W  RAM write data.
REQ-013 SHALL have port ram_raddr  output  ADDR_W  RAM read address.
REQ-014 SHALL have port play_valid  output  1  high while RAM read data is a note to sound.
REQ-015 SHALL have port note_count  output  ADDR_W+1  number of notes stored.
REQ-016 SHALL have port full  output  1  note_count == 2^ADDR_W.
REQ-017 SHALL have port state_o  output  2  current state encoding (IDLE=0, REC=1, PLAY=2).

Function
REQ-018 SHALL implement states IDLE, REC, PLAY; all outputs registered.
REQ-019 SHALL resolve simultaneous pulses with priority start_p > execute_p > record_p; lower-priority pulses in that cycle are dropped.
REQ-020 In any state, start_p SHALL clear note_count to 0, ram_raddr to 0, drop play_valid and enter REC next cycle.
REQ-021 In REC, record_p with full=0 SHALL, on the next cycle, assert ram_we for one cycle with ram_waddr=note_count and ram_wdata=sw_tones sampled at the pulse; note_count SHALL increment on that same edge.
REQ-022 record_p SHALL be ignored when full=1 or when state is IDLE or PLAY.
REQ-023 execute_p in IDLE or REC with note_count>0 SHALL enter PLAY with ram_raddr=0 and play_valid=1 on the next cycle; with note_count=0 it SHALL be ignored.
REQ-024 In PLAY, ram_raddr SHALL hold for exactly TICK_DIV cycles, then advance by 1.
REQ-025 When the tick expires at ram_raddr==note_count-1, the block SHALL enter IDLE, ram_raddr=0, play_valid=0 (non-loop build).
REQ-026 execute_p in PLAY SHALL be ignored; note_count SHALL be unchanged by playback.
REQ-027 ram_waddr arithmetic SHALL use the low ADDR_W bits of note_count; note_count never exceeds 2^ADDR_W.
REQ-028 The tick counter SHALL reset to 0 on every PLAY entry and when PLAY is left.

Reset
REQ-029 reset low SHALL immediately force state IDLE, note_count=0, ram_we=0, ram_waddr=0, ram_wdata=0, ram_raddr=0, play_valid=0, full=0, tick counter=0, including mid-write or mid-playback.
REQ-030 RAM contents SHALL not be touched by reset; old data is unreachable because note_count=0.

Configuration
REQ-031 With macro NOTE_SEQ_LOOP_PLAYBACK_EN defined, the tick expiring at the last note SHALL wrap ram_raddr to 0 and stay in PLAY until start_p or reset.
REQ-032 Without NOTE_SEQ_LOOP_PLAYBACK_EN, REQ-025 SHALL apply.

Structure
REQ-033 Shared package SHALL hold the state enum typedef (2 bits), default ADDR_W/NOTE_W constants and the TICK_DIV default.
REQ-034 The tick divider SHALL be a sub-module note_tick_gen (enable in, one-cycle tick out, counter clear on enable low).

Verification (TICK_DIV=4)
REQ-035 start_p; record_p with sw_tones=0x01,0x04,0x80 -> three ram_we pulses at waddr 0,1,2 with data 0x01,0x04,0x80; note_count=3.
REQ-036 execute_p -> ram_raddr 0,1,2 each held 4 cycles, play_valid high 12 cycles, then IDLE, raddr=0.
REQ-037 execute_p with note_count=0 -> state stays, play_valid stays 0.
REQ-038 64 record_p pulses -> full=1, note_count=64; 65th pulse -> no ram_we.
REQ-039 start_p and record_p same cycle -> REC, note_count=0, no ram_we; reset low during PLAY at raddr=1 -> all outputs 0 in same cycle.
REQ-040 NOTE_SEQ_LOOP_PLAYBACK_EN, 2 notes -> raddr sequence 0,1,0,1,... until start_p, then REC.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// Shared types and default parameters for the note sequencer and its tick divider.
package note_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_t;

  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_NOTE_W   = 8;
  localparam int DEF_TICK_DIV = 25000000;

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// Note-duration divider: while enabled, emits a registered one-cycle tick every
// TICK_DIV cycles, aligned to the last cycle of each note; clears when disabled.
module note_tick_gen
  import note_sequencer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] cnt_reg;

  // The tick is registered one count early so it is high during the final
  // cycle of each note, letting the consumer advance on that cycle's edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (!enable) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else begin
      cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      tick    <= (cnt_reg == CNT_PRE);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback sequencer for a note RAM with IDLE/REC/PLAY states.
// Define NOTE_SEQ_LOOP_PLAYBACK_EN to make playback wrap instead of ending.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NOTE_W   = DEF_NOTE_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_p,
  input  logic              record_p,
  input  logic              execute_p,
  input  logic [NOTE_W-1:0] sw_tones,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [NOTE_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              play_valid,
  output logic [ADDR_W:0]   note_count,
  output logic              full,
  output logic [1:0]        state_o
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  seq_state_t        state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [NOTE_W-1:0] wdata_reg, wdata_next;
  logic [ADDR_W-1:0] raddr_reg, raddr_next;
  logic              valid_reg, valid_next;
  logic              full_reg, full_next;
  logic              play_en;
  logic              tick;
  logic              last_note;

  assign play_en = (state_reg == ST_PLAY);

  note_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .enable(play_en),
    .tick  (tick)
  );

  assign last_note = ({1'b0, raddr_reg} == (count_reg - 1'b1));

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    raddr_next = raddr_reg;
    valid_next = valid_reg;

    if (start_p) begin
      state_next = ST_REC;
      count_next = '0;
      raddr_next = '0;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_REC: begin
          // A pending execute always shadows a same-cycle record, even when
          // the execute itself is ignored for lack of notes.
          if (execute_p) begin
            if (count_reg != '0) begin
              state_next = ST_PLAY;
              raddr_next = '0;
              valid_next = 1'b1;
            end
          end else if (record_p && (state_reg == ST_REC) && !full_reg) begin
            we_next    = 1'b1;
            waddr_next = count_reg[ADDR_W-1:0];
            wdata_next = sw_tones;
            count_next = count_reg + 1'b1;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (last_note) begin
`ifdef NOTE_SEQ_LOOP_PLAYBACK_EN
              raddr_next = '0;
`else
              state_next = ST_IDLE;
              raddr_next = '0;
              valid_next = 1'b0;
`endif
            end else begin
              raddr_next = raddr_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          raddr_next = '0;
          valid_next = 1'b0;
        end
      endcase
    end

    full_next = (count_next == DEPTH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      raddr_reg <= '0;
      valid_reg <= 1'b0;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      raddr_reg <= raddr_next;
      valid_reg <= valid_next;
      full_reg  <= full_next;
    end
  end

  assign ram_we     = we_reg;
  assign ram_waddr  = waddr_reg;
  assign ram_wdata  = wdata_reg;
  assign ram_raddr  = raddr_reg;
  assign play_valid = valid_reg;
  assign note_count = count_reg;
  assign full       = full_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus pushes expected RAM writes and
// playback addresses into queues, a negedge monitor pops and compares them.
module tb_note_sequencer;

  localparam int ADDR_W   = 6;
  localparam int NOTE_W   = 8;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 64;
  localparam int LOOPS    = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start_p = 1'b0;
  logic              record_p = 1'b0;
  logic              execute_p = 1'b0;
  logic [NOTE_W-1:0] sw_tones = '0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [NOTE_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic              play_valid;
  logic [ADDR_W:0]   note_count;
  logic              full;
  logic [1:0]        state_o;

  note_sequencer #(
    .ADDR_W(ADDR_W),
    .NOTE_W(NOTE_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_p(start_p),
    .record_p(record_p),
    .execute_p(execute_p),
    .sw_tones(sw_tones),
    .ram_we(ram_we),
    .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr),
    .play_valid(play_valid),
    .note_count(note_count),
    .full(full),
    .state_o(state_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t wr_q[$];
  int  play_q[$];

  // Reference model: 0 idle, 1 recording, 2 playing
  int m_state = 0;
  int m_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    wr_t w;
    int  a;
    if (reset) begin
      if (ram_we) begin
        if (wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_we: got waddr %0d data %0h expected no write", ram_waddr, ram_wdata);
        end else begin
          w = wr_q.pop_front();
          check("ram_waddr", 32'(ram_waddr), w.addr);
          check("ram_wdata", 32'(ram_wdata), w.data);
          $display("[TB] write addr=%0d data=%02h", ram_waddr, ram_wdata);
        end
      end
      if (play_valid) begin
        if (play_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_play: got raddr %0d expected play_valid 0", ram_raddr);
        end else begin
          a = play_q.pop_front();
          check("ram_raddr", 32'(ram_raddr), a);
        end
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called at posedge+1; drives a one-cycle pulse set sampled by the next edge.
  task automatic drive(input bit s, input bit r, input bit e, input logic [NOTE_W-1:0] tones);
    start_p   = s;
    record_p  = r;
    execute_p = e;
    sw_tones  = tones;
    @(posedge clock);
    #1;
    start_p   = 1'b0;
    record_p  = 1'b0;
    execute_p = 1'b0;
  endtask

  task automatic push_play(input int loops);
    for (int l = 0; l < loops; l++)
      for (int n = 0; n < m_count; n++)
        for (int k = 0; k < TICK_DIV; k++)
          play_q.push_back(n);
  endtask

  task automatic step(input bit s, input bit r, input bit e, input logic [NOTE_W-1:0] tones);
    int c0;
    drive(s, r, e, tones);
    if (s) begin
      m_count = 0;
      m_state = 1;
      play_q.delete();
    end else if (e) begin
      if (m_state != 2 && m_count > 0) begin
        m_state = 2;
        c0 = cyc;
`ifdef NOTE_SEQ_LOOP_PLAYBACK_EN
        push_play(LOOPS);
        wait_until(c0 + LOOPS * TICK_DIV * m_count - 1);
        check("loop_pending", 32'(play_q.size()), 1);
        step(1'b1, 1'b0, 1'b0, '0);
        check("loop_abort_state", 32'(state_o), 1);
`else
        push_play(1);
        wait_until(c0 + TICK_DIV * m_count);
        m_state = 0;
        check("play_end_state", 32'(state_o), 0);
        check("play_end_raddr", 32'(ram_raddr), 0);
        check("play_end_valid", 32'(play_valid), 0);
        check("play_q_drained", 32'(play_q.size()), 0);
`endif
      end
    end else if (r) begin
      if (m_state == 1 && m_count < DEPTH) begin
        wr_q.push_back('{addr: m_count % DEPTH, data: int'(tones)});
        m_count++;
      end
    end
    $display("[TB] pulse s=%0d r=%0d e=%0d tones=%02h -> state=%0d count=%0d", s, r, e, tones, state_o, note_count);
  endtask

  task automatic check_state(input string tag);
    @(posedge clock);
    #1;
    check({tag, "_state"}, 32'(state_o), m_state);
    check({tag, "_count"}, 32'(note_count), m_count);
    check({tag, "_full"}, 32'(full), 32'(m_count == DEPTH));
    check({tag, "_wr_q"}, 32'(wr_q.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state_o), 0);
    check({tag, "_count"}, 32'(note_count), 0);
    check({tag, "_we"}, 32'(ram_we), 0);
    check({tag, "_waddr"}, 32'(ram_waddr), 0);
    check({tag, "_wdata"}, 32'(ram_wdata), 0);
    check({tag, "_raddr"}, 32'(ram_raddr), 0);
    check({tag, "_valid"}, 32'(play_valid), 0);
    check({tag, "_full"}, 32'(full), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int k;
    bit rs;
    bit re;

    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Execute with no notes, record while idle: both ignored.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_state("exec_empty_idle");
    step(1'b0, 1'b1, 1'b0, 8'h55);
    check_state("rec_in_idle");

    // Three notes, then playback.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h04);
    step(1'b0, 1'b1, 1'b0, 8'h80);
    check_state("three_notes");
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_state("after_play");

    // Execute in REC with zero notes.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_state("exec_empty_rec");

    // Start wins over record; execute wins over record.
    step(1'b0, 1'b1, 1'b0, 8'h11);
    step(1'b0, 1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 1'b0, 8'h33);
    check_state("start_and_record");
    step(1'b0, 1'b1, 1'b0, 8'h44);
    step(1'b0, 1'b1, 1'b1, 8'h66);
    check_state("exec_and_record");

    // Fill the RAM, overflow attempt, then play all of it.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 1'b0, NOTE_W'($urandom));
    check_state("full");
    step(1'b0, 1'b1, 1'b0, 8'hA5);
    check_state("overflow");
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_state("full_play");

    // Pulses during PLAY are ignored; start aborts playback.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h0A);
    step(1'b0, 1'b1, 1'b0, 8'h0B);
    step(1'b0, 1'b1, 1'b0, 8'h0C);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    m_state = 2;
    c0 = cyc;
    push_play(1);
    drive(1'b0, 1'b1, 1'b1, 8'h77);
    drive(1'b0, 1'b1, 1'b0, 8'h78);
    check("play_count_kept", 32'(note_count), 3);
    wait_until(c0 + 6);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_state("abort_play");

    // Reset asserted mid-playback at raddr 1.
    step(1'b0, 1'b1, 1'b0, 8'h21);
    step(1'b0, 1'b1, 1'b0, 8'h42);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    m_state = 2;
    c0 = cyc;
    push_play(1);
    wait_until(c0 + 5);
    check("raddr_before_reset", 32'(ram_raddr), 1);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    play_q.delete();
    m_state = 0;
    m_count = 0;
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_state("post_reset");

    // Randomised sessions.
    for (int it = 0; it < 15; it++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clock);
          #1;
        end
        rs = ($urandom_range(0, 15) == 0);
        re = ($urandom_range(0, 9) == 0);
        step(rs, 1'b1, re, NOTE_W'($urandom));
      end
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check_state("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
